// File: rtl/result_write_arbiter.sv
// Round-robin arbiter that serialises detector hits into 3-beat result writes.
// Optional RESULT_DROP_CNT_EN: drop (grant without write) when the FIFO is full.
`timescale 1ns/1ps
module result_write_arbiter #(
  parameter int DATA_WIDTH_12 = 12,
  parameter int NUM_RESIZE    = 5,
  parameter int NUM_REQ       = 5,
  parameter int FIFO_DEPTH    = 4096,
  parameter int NUM_VARIABLE  = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ*DATA_WIDTH_12-1:0]   req_x,
  input  logic [NUM_REQ*DATA_WIDTH_12-1:0]   req_y,
  input  logic [NUM_REQ*NUM_RESIZE-1:0]      req_cand,
  output logic [NUM_REQ-1:0]                 grant,
  output logic                               write_result,
  output logic [DATA_WIDTH_12-1:0]           ori_x,
  output logic [DATA_WIDTH_12-1:0]           ori_y,
  output logic [NUM_RESIZE-1:0]              candidate,
  input  logic                               write_result_end,
  input  logic [DATA_WIDTH_12-1:0]           fifo_usedw,
  input  logic                               rec_read,
  output logic [DATA_WIDTH_12-1:0]           o_record_cnt,
  output logic                               o_busy,
  output logic                               o_seq_err
`ifdef RESULT_DROP_CNT_EN
  ,
  output logic [15:0]                        o_drop_cnt
`endif
);

  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = FIFO_DEPTH / NUM_VARIABLE;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [1:0]               beat_q, beat_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic                     wr_q, wr_d;
  logic [DATA_WIDTH_12-1:0] x_q, x_d;
  logic [DATA_WIDTH_12-1:0] y_q, y_d;
  logic [NUM_RESIZE-1:0]    c_q, c_d;
  logic [DATA_WIDTH_12-1:0] cnt_q, cnt_d;
  logic                     end_exp_q, end_exp_d;
  logic                     err_q, err_d;

  logic                     found;
  logic [PW-1:0]            win;
  logic                     space_ok;
  logic                     arb_en;
  logic                     rec_end;
  logic                     rd_ok;
  logic [DATA_WIDTH_12-1:0] win_x;
  logic [DATA_WIDTH_12-1:0] win_y;
  logic [NUM_RESIZE-1:0]    win_c;

  function automatic logic [PW-1:0] rr_idx(
    input logic [PW-1:0] base,
    input int            off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  // First pending request at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[rr_idx(ptr_q, k)]) begin
        found = 1'b1;
        win   = rr_idx(ptr_q, k);
      end
    end
  end

  // Two records of margin because usedw lags the writes.
  assign space_ok = (32'(fifo_usedw) + 32'(2 * NUM_VARIABLE))
                    <= 32'(FIFO_DEPTH);

  // A grant pulse blocks re-arbitration so a stale req is not granted twice.
  assign arb_en  = (state_q == S_IDLE) && found && (grant_q == '0);
  assign rec_end = (state_q == S_WRITE) && (beat_q == 2'd2);
  assign rd_ok   = rec_read && (cnt_q != '0);

  assign win_x = req_x[DATA_WIDTH_12*win +: DATA_WIDTH_12];
  assign win_y = req_y[DATA_WIDTH_12*win +: DATA_WIDTH_12];
  assign win_c = req_cand[NUM_RESIZE*win +: NUM_RESIZE];

`ifdef RESULT_DROP_CNT_EN
  logic        drop_hit;
  logic [15:0] drop_q, drop_d;
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    wr_d    = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
`ifdef RESULT_DROP_CNT_EN
    drop_hit = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (arb_en) begin
          if (space_ok) begin
            grant_d = NUM_REQ'(1) << win;
            wr_d    = 1'b1;
            x_d     = win_x;
            y_d     = win_y;
            c_d     = win_c;
            beat_d  = 2'd0;
            ptr_d   = rr_idx(win, 1);
            state_d = S_WRITE;
          end
`ifdef RESULT_DROP_CNT_EN
          else begin
            grant_d  = NUM_REQ'(1) << win;
            ptr_d    = rr_idx(win, 1);
            drop_hit = 1'b1;
          end
`endif
        end
      end
      S_WRITE: begin
        if (beat_q == 2'd2) begin
          state_d = S_IDLE;
        end else begin
          wr_d   = 1'b1;
          beat_d = beat_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({rec_end, rd_ok})
      2'b10: begin
        if (cnt_q != DATA_WIDTH_12'(CNT_MAX)) cnt_d = cnt_q + 1'b1;
      end
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // The end strobe must appear exactly one cycle after beat 2.
  assign end_exp_d = rec_end;
  assign err_d     = err_q | (end_exp_q ^ write_result_end);

`ifdef RESULT_DROP_CNT_EN
  always_comb begin
    drop_d = drop_q;
    if (drop_hit && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign o_drop_cnt = drop_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      wr_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      c_q       <= '0;
      cnt_q     <= '0;
      end_exp_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      wr_q      <= wr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      end_exp_q <= end_exp_d;
      err_q     <= err_d;
    end
  end

  assign grant        = grant_q;
  assign write_result = wr_q;
  assign ori_x        = x_q;
  assign ori_y        = y_q;
  assign candidate    = c_q;
  assign o_record_cnt = cnt_q;
  assign o_busy       = (state_q == S_WRITE);
  assign o_seq_err    = err_q;

endmodule

// File: tb/tb_result_write_arbiter.sv
// Bench for result_write_arbiter: scoreboard of expected records checked
// against grant and the three write beats.
`timescale 1ns/1ps
module tb_result_write_arbiter;

  localparam int NR = 5;

  typedef struct {
    logic [4:0]  g;
    logic [11:0] x;
    logic [11:0] y;
    logic [4:0]  c;
    bit          wr;
  } rec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    req;
  logic [59:0]   req_x;
  logic [59:0]   req_y;
  logic [24:0]   req_cand;
  logic [4:0]    grant;
  logic          write_result;
  logic [11:0]   ori_x;
  logic [11:0]   ori_y;
  logic [4:0]    candidate;
  logic          write_result_end;
  logic [11:0]   fifo_usedw;
  logic          rec_read;
  logic [11:0]   o_record_cnt;
  logic          o_busy;
  logic          o_seq_err;
`ifdef RESULT_DROP_CNT_EN
  logic [15:0]   o_drop_cnt;
`endif

  result_write_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .req_x            (req_x),
    .req_y            (req_y),
    .req_cand         (req_cand),
    .grant            (grant),
    .write_result     (write_result),
    .ori_x            (ori_x),
    .ori_y            (ori_y),
    .candidate        (candidate),
    .write_result_end (write_result_end),
    .fifo_usedw       (fifo_usedw),
    .rec_read         (rec_read),
    .o_record_cnt     (o_record_cnt),
    .o_busy           (o_busy),
    .o_seq_err        (o_seq_err)
`ifdef RESULT_DROP_CNT_EN
    ,
    .o_drop_cnt       (o_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t exp_q[$];
  rec_t cur;
  int   nbeat = 0;
  bit   lowchk = 0;

  logic [11:0] sx[NR];
  logic [11:0] sy[NR];
  logic [4:0]  sc[NR];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void push(input int i, input bit wr);
    rec_t r;
    r.g  = 5'(1 << i);
    r.x  = sx[i];
    r.y  = sy[i];
    r.c  = sc[i];
    r.wr = wr;
    exp_q.push_back(r);
  endfunction

  // Output monitor: pops one expectation per grant, then checks the beats.
  always @(negedge clk) begin
    if (reset) begin
      nbeat  = 0;
      lowchk = 0;
    end else begin
      if (grant !== 5'b0) begin
        if (exp_q.size() == 0) begin
          chk("grant_unexpected", 64'(grant), 64'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("grant", 64'(grant), 64'(cur.g));
          chk("grant_req", 64'(grant & ~req), 64'd0);
          nbeat  = cur.wr ? 3 : 0;
          lowchk = 1;
        end
      end
      if (nbeat > 0) begin
        chk("beat", 64'({write_result, o_busy, ori_x, ori_y, candidate}),
            64'({1'b1, 1'b1, cur.x, cur.y, cur.c}));
        nbeat--;
      end else if (lowchk) begin
        chk("wr_low", 64'(write_result), 64'd0);
        lowchk = 0;
      end
    end
  end

  task automatic run_record(input int budget, input logic [4:0] clr,
                            input bit send_end, input bit rd_end,
                            output int waited);
    bit got;
    got    = 0;
    waited = 0;
    while (!got && waited < budget) begin
      @(negedge clk);
      waited++;
      if (grant !== 5'b0) got = 1;
    end
    chk("grant_seen", 64'(got), 64'd1);
    if (!got) return;
    @(posedge clk); #1 req = req & ~clr;
    @(posedge clk); #1 rec_read = rd_end;
    @(posedge clk); #1 rec_read = 1'b0; write_result_end = send_end;
    @(posedge clk); #1 write_result_end = 1'b0;
  endtask

  task automatic pulse_read();
    @(posedge clk); #1 rec_read = 1'b1;
    @(posedge clk); #1 rec_read = 1'b0;
  endtask

  int w;
  bit seen;

  initial begin
    reset = 1'b1;
    req = '0;
    write_result_end = 1'b0;
    fifo_usedw = '0;
    rec_read = 1'b0;
    for (int i = 0; i < NR; i++) begin
      sx[i] = 12'h100 + 12'(i);
      sy[i] = 12'h200 + 12'(i);
      sc[i] = 5'(1 << i) | 5'b10000;
    end
    sx[2] = 12'h010;
    sy[2] = 12'h020;
    sc[2] = 5'b00100;
    for (int i = 0; i < NR; i++) begin
      req_x[12*i +: 12]   = sx[i];
      req_y[12*i +: 12]   = sy[i];
      req_cand[5*i +: 5]  = sc[i];
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_outs", 64'({grant, write_result, ori_x, ori_y, candidate}),
        64'd0);
    chk("rst_cnt", 64'(o_record_cnt), 64'd0);
    chk("rst_busy_err", 64'({o_busy, o_seq_err}), 64'd0);

    // single request on slot 2
    push(2, 1);
    req = 5'b00100;
    run_record(20, 5'h1F, 1, 0, w);
    chk("cnt_single", 64'(o_record_cnt), 64'd1);
    chk("err_single", 64'(o_seq_err), 64'd0);
    chk("busy_idle", 64'(o_busy), 64'd0);

    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("cnt_after_rst", 64'(o_record_cnt), 64'd0);

    // continuous requests: rotate 0..4 then 0, one grant per 4 cycles
    push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(4, 1); push(0, 1);
    req = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      run_record(40, (i == 5) ? 5'h1F : 5'h00, 1, 0, w);
      if (i > 0) chk("period", 64'(w), 64'd1);
    end
    chk("cnt_rr", 64'(o_record_cnt), 64'd6);

    // FIFO space guard
    fifo_usedw = 12'd4091;
    req = 5'b00001;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (grant !== 5'b0) seen = 1;
    end
    chk("nospace", 64'(seen), 64'd0);
    push(0, 1);
    fifo_usedw = 12'd4090;
    run_record(20, 5'h1F, 1, 0, w);
    fifo_usedw = 12'd0;
    chk("cnt_space", 64'(o_record_cnt), 64'd7);

    // record count: down to 3, coincident end and read, drain, underflow
    repeat (4) pulse_read();
    @(negedge clk);
    chk("cnt_read4", 64'(o_record_cnt), 64'd3);
    push(1, 1);
    req = 5'b00010;
    run_record(20, 5'h1F, 1, 1, w);
    chk("cnt_coinc", 64'(o_record_cnt), 64'd3);
    repeat (3) pulse_read();
    @(negedge clk);
    chk("cnt_drain", 64'(o_record_cnt), 64'd0);
    pulse_read();
    @(negedge clk);
    chk("cnt_underflow", 64'(o_record_cnt), 64'd0);
    chk("err_before", 64'(o_seq_err), 64'd0);

    // missing end strobe sets a sticky error
    push(4, 1);
    req = 5'b10000;
    run_record(20, 5'h1F, 0, 0, w);
    @(negedge clk);
    chk("seq_err_set", 64'(o_seq_err), 64'd1);
    repeat (5) @(negedge clk);
    chk("seq_err_sticky", 64'(o_seq_err), 64'd1);

    // reset during beat 1
    push(2, 1);
    req = 5'b00100;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (grant !== 5'b0) seen = 1;
    end
    chk("mid_grant", 64'(seen), 64'd1);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    chk("mid_rst_outs",
        64'({grant, write_result, o_busy, ori_x, ori_y, candidate}), 64'd0);
    chk("mid_rst_cnt_err", 64'({o_record_cnt, o_seq_err}), 64'd0);
    req = 5'b11111;
    push(0, 1);
    @(posedge clk); #1 reset = 1'b0;
    run_record(20, 5'h1F, 1, 0, w);
    chk("post_rst_cnt", 64'(o_record_cnt), 64'd1);

`ifdef RESULT_DROP_CNT_EN
    fifo_usedw = 12'd4091;
    push(0, 0);
    req = 5'b00001;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (grant !== 5'b0) seen = 1;
    end
    #1 req = 5'b00000;
    chk("drop_grant", 64'(seen), 64'd1);
    repeat (4) @(negedge clk);
    chk("drop_cnt", 64'(o_drop_cnt), 64'd1);
    chk("drop_rec_cnt", 64'(o_record_cnt), 64'd1);
    chk("drop_err", 64'(o_seq_err), 64'd0);
    fifo_usedw = 12'd0;
`endif

    repeat (4) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
